// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: target side of the quad-SPI read link.
// Decodes command/address/mode/dummy phases clocked in by the initiator and
// streams little-endian words from a backing word memory onto the data lines,
// with a one-word prefetch buffer and a sticky underrun flag.
// Optional feature: define QSPI_RESP_SINGLE_READ_EN to also accept command 0x03
// (single-line read, data on qspi_io_i[1]).
module qspi_flash_responder #(
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              qspi_ck_o,
    input  logic              qspi_cs_o,
    input  logic [3:0]        qspi_io_o,
    output logic [3:0]        qspi_io_i,
    output logic              qspi_oe,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              err_underrun
);

    localparam int CNT_W    = 8;
    localparam int ADDR_NIB = ADDR_W / 4;
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-3:0] IDX_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
    } state_t;

    // ---------------- synchronisers ----------------
    logic [2:0] ck_sync_q;
    logic [1:0] cs_sync_q;
    logic [3:0] io_s1_q, io_s2_q;

    // two-flop synchronisers; third ck flop gives the edge detector its history
    always_ff @(posedge clk) begin
        if (rst) begin
            ck_sync_q <= 3'b000;
            cs_sync_q <= 2'b11;
            io_s1_q   <= 4'h0;
            io_s2_q   <= 4'h0;
        end else begin
            ck_sync_q <= {ck_sync_q[1:0], qspi_ck_o};
            cs_sync_q <= {cs_sync_q[0], qspi_cs_o};
            io_s1_q   <= qspi_io_o;
            io_s2_q   <= io_s1_q;
        end
    end

    logic sck_rise, sck_fall, cs_act;
    logic [3:0] io_s;
    assign sck_rise = ck_sync_q[1] & ~ck_sync_q[2];
    assign sck_fall = ~ck_sync_q[1] & ck_sync_q[2];
    assign cs_act   = ~cs_sync_q[1];
    assign io_s     = io_s2_q;

    // ---------------- state ----------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] sh_q, sh_d;        // command / address shift register
    logic              single_q, single_d;
    logic [31:0]       word_q, word_d;    // word currently being shifted out
    logic              word_vld_q, word_vld_d;
    logic [4:0]        pos_q, pos_d;      // nibble (quad) or bit (single) index in word
    logic [ADDR_W-3:0] widx_q, widx_d;    // next word index to fetch
    logic [31:0]       pf_q, pf_d;        // one-word prefetch buffer
    logic              pf_vld_q, pf_vld_d;
    logic              pend_q, pend_d;    // memory request outstanding
    logic              drop_q, drop_d;    // outstanding response belongs to an aborted read
    logic [3:0]        io_q, io_d;
    logic              oe_q, oe_d;
    logic              req_q, req_d;
    logic [ADDR_W-3:0] maddr_q, maddr_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    // output value for a word position: quad = byte high nibble first,
    // single = byte MSB first on io[1]; bytes little-endian in both modes
    function automatic logic [3:0] pick(input logic [31:0] w, input logic [4:0] p,
                                        input logic single);
        logic [7:0] b;
        if (single) begin
            b = w[{p[4:3], 3'b000} +: 8];
            return {2'b00, b[3'd7 - p[2:0]], 1'b0};
        end
        b = w[{p[2:1], 3'b000} +: 8];
        return p[0] ? b[3:0] : b[7:4];
    endfunction

    logic              reload, issue, rsp_ok;
    logic [7:0]        cmd_byte;
    logic [ADDR_W-3:0] first_idx;
    logic [CNT_W-1:0]  dummy_tgt;
    logic [4:0]        last_pos;

    // next-state: phase decode, data streaming, prefetch and CS abort handling
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        single_d   = single_q;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        pos_d      = pos_q;
        widx_d     = widx_q;
        pf_d       = pf_q;
        pf_vld_d   = pf_vld_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        req_d      = 1'b0;
        maddr_d    = maddr_q;
        err_d      = err_q;
        reload     = 1'b0;
        issue      = 1'b0;
        cmd_byte   = {sh_q[6:0], io_s[0]};
        first_idx  = '0;
        dummy_tgt  = single_q ? '0 : CNT_W'(DUMMY_CYCLES);
        last_pos   = single_q ? 5'd31 : 5'd7;

        // responses from an aborted read are swallowed here
        rsp_ok = mem_rvalid & ~drop_q;
        if (mem_rvalid) begin
            pend_d = 1'b0;
            drop_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cs_act) begin
                    state_d  = S_CMD;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    single_d = 1'b0;
                end
            end
            S_CMD: begin
                if (sck_rise) begin
                    sh_d  = {sh_q[ADDR_W-2:0], io_s[0]};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (cmd_byte == 8'hEB) begin
                            state_d = S_ADDR;
`ifdef QSPI_RESP_SINGLE_READ_EN
                        end else if (cmd_byte == 8'h03) begin
                            state_d  = S_ADDR;
                            single_d = 1'b1;
`endif
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
            end
            S_ADDR: begin
                if (sck_rise) begin
                    sh_d  = single_q ? {sh_q[ADDR_W-2:0], io_s[0]}
                                     : {sh_q[ADDR_W-5:0], io_s};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == (single_q ? CNT_W'(ADDR_W-1) : CNT_W'(ADDR_NIB-1))) begin
                        cnt_d     = '0;
                        state_d   = single_q ? S_DUMMY : S_MODE;
                        // first word fetched while mode/dummy cycles go by
                        first_idx = sh_d[ADDR_W-1:2];
                        req_d     = 1'b1;
                        maddr_d   = first_idx;
                        widx_d    = first_idx + IDX_ONE;
                        pend_d    = 1'b1;
                        pf_vld_d  = 1'b0;
                    end
                end
            end
            S_MODE: begin
                if (sck_rise) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DUMMY;
                    end
                end
            end
            S_DUMMY: begin
                if (sck_rise && cnt_q < dummy_tgt)
                    cnt_d = cnt_q + CNT_ONE;
                // data starts on the fall that closes the last dummy cycle
                if (sck_fall && cnt_q == dummy_tgt) begin
                    state_d = S_DATA;
                    pos_d   = single_q ? {sh_q[1:0], 3'b000} : {2'b00, sh_q[1:0], 1'b0};
                    reload  = 1'b1;
                end
            end
            S_DATA: begin
                if (sck_fall) begin
                    if (pos_q == last_pos) begin
                        pos_d  = '0;
                        reload = 1'b1;
                    end else begin
                        pos_d = pos_q + 5'd1;
                    end
                end
            end
            default: ;  // S_IGNORE: wait for CS to go away
        endcase

        // word handoff: reload from prefetch, late load after underrun, or fill prefetch
        if (reload) begin
            if (pf_vld_q || rsp_ok) begin
                word_d     = pf_vld_q ? pf_q : mem_rdata;
                word_vld_d = 1'b1;
                pf_vld_d   = 1'b0;
                issue      = 1'b1;
            end else begin
                word_vld_d = 1'b0;
                err_d      = 1'b1;
            end
        end else if (rsp_ok && state_q == S_DATA && !word_vld_q) begin
            // late word keeps the current position; no catching up
            word_d     = mem_rdata;
            word_vld_d = 1'b1;
            issue      = 1'b1;
        end else if (rsp_ok && state_q != S_IDLE) begin
            pf_d     = mem_rdata;
            pf_vld_d = 1'b1;
        end

        if (issue) begin
            req_d   = 1'b1;
            maddr_d = widx_q;
            widx_d  = widx_q + IDX_ONE;
            pend_d  = 1'b1;
        end

        // CS released: abandon everything, remember to discard an in-flight response
        if (!cs_act && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            pf_vld_d   = 1'b0;
            word_vld_d = 1'b0;
            req_d      = 1'b0;
            maddr_d    = maddr_q;
            pend_d     = 1'b0;
            drop_d     = pend_q & ~mem_rvalid;
        end

        io_d   = (state_d == S_DATA && word_vld_d) ? pick(word_d, pos_d, single_q) : 4'h0;
        oe_d   = (state_d == S_DATA);
        busy_d = (state_d != S_IDLE);
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            single_q   <= 1'b0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            pos_q      <= '0;
            widx_q     <= '0;
            pf_q       <= '0;
            pf_vld_q   <= 1'b0;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
            io_q       <= 4'h0;
            oe_q       <= 1'b0;
            req_q      <= 1'b0;
            maddr_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            single_q   <= single_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            pos_q      <= pos_d;
            widx_q     <= widx_d;
            pf_q       <= pf_d;
            pf_vld_q   <= pf_vld_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            io_q       <= io_d;
            oe_q       <= oe_d;
            req_q      <= req_d;
            maddr_q    <= maddr_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign qspi_io_i    = io_q;
    assign qspi_oe      = oe_q;
    assign mem_req      = req_q;
    assign mem_addr     = maddr_q;
    assign busy         = busy_q;
    assign err_underrun = err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: table of directed reads, abort, underrun,
// reset and randomized reads checked against a byte-level memory model.
module tb_qspi_flash_responder;
    localparam int ADDR_W = 24;
    localparam int DUMMY  = 4;
    localparam int H      = 6;   // SCK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ck = 1'b0, cs = 1'b1;
    logic [3:0]  io_o = 4'h0;
    logic [3:0]  io_i;
    logic        oe, mem_req, mem_rvalid, busy, err;
    logic [21:0] mem_addr;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    qspi_flash_responder #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY)) dut (
        .clk(clk), .rst(rst), .qspi_ck_o(ck), .qspi_cs_o(cs), .qspi_io_o(io_o),
        .qspi_io_i(io_i), .qspi_oe(oe), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .err_underrun(err)
    );

    logic [31:0] mem [0:63];
    int n_cmp = 0, n_bad = 0;
    int req_cnt = 0, slow_req = -1, slow_lat = 0, stub_left = 0;
    bit stub_overlap = 0;
    int req_idx[$];
    logic [3:0] rx[$];
    bit oe_early, oe_missing;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [63:0] exp;
        bit          ign;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // memory stub: one request at a time, latency random or deliberately slow
    initial begin
        int left;
        logic [21:0] a;
        left = 0; a = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[a[5:0]];
                end
            end
            if (mem_req) begin
                if (left > 0) stub_overlap = 1;
                a = mem_addr;
                req_idx.push_back(int'(mem_addr));
                left = (req_cnt == slow_req) ? slow_lat : int'($urandom_range(1, 4));
                req_cnt++;
            end
            stub_left = left;
        end
    end

    // reference model: byte-addressed view of the word memory
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [3:0] exp_unit(input logic [23:0] a, input int k, input bit single);
        logic [7:0] b;
        if (single) begin
            b = mem_byte(a + 24'(k / 8));
            return {2'b00, b[7 - (k % 8)], 1'b0};
        end
        b = mem_byte(a + 24'(k / 2));
        return (k % 2) ? b[3:0] : b[7:4];
    endfunction

    task automatic sck_bit(input logic [3:0] d);
        io_o = d;
        clk_n(H);
        if (oe) oe_early = 1;
        ck = 1'b1;
        clk_n(H);
        ck = 1'b0;
    endtask

    // one CS-framed transaction; received units land in rx
    task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int n, input bit single);
        rx.delete(); req_idx.delete(); req_cnt = 0; oe_early = 0; oe_missing = 0;
        cs = 1'b0;
        clk_n(4);
        for (int i = 7; i >= 0; i--) sck_bit({3'b000, cmd[i]});
        if (cmd == 8'hEB) begin
            for (int i = 5; i >= 0; i--) sck_bit(addr[4*i +: 4]);
            sck_bit(4'h0); sck_bit(4'h0);
            for (int i = 0; i < DUMMY; i++) sck_bit(4'h0);
        end else if (single) begin
            for (int i = 23; i >= 0; i--) sck_bit({3'b000, addr[i]});
        end else begin
            for (int i = 0; i < 16; i++) sck_bit(4'h0);
        end
        for (int k = 0; k < n; k++) begin
            clk_n(H);
            rx.push_back(io_i);
            if (!oe) oe_missing = 1;
            ck = 1'b1;
            clk_n(H);
            ck = 1'b0;
        end
        clk_n(2);
        cs = 1'b1;
        clk_n(4);
        chk("busy_after_cs", busy, 0);
        chk("oe_after_cs", oe, 0);
        clk_n(6);
    endtask

    task automatic chk_read(input string nm, input logic [23:0] addr, input int n, input bit single);
        logic [21:0] i0;
        i0 = addr[23:2];
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_unit%0d", nm, k), rx[k], exp_unit(addr, k, single));
        chk({nm, "_nreq"}, req_idx.size() >= 2, 1);
        chk({nm, "_req0"}, req_idx[0], i0);
        chk({nm, "_req1"}, req_idx[1], 22'(i0 + 22'd1));
        chk({nm, "_oe_window"}, {oe_early, oe_missing}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nz;
        logic [23:0] ra;
        int rn;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0403_0201; mem[1] = 32'h0807_0605;
        mem[2]  = 32'h0C0B_0A09; mem[3] = 32'h100F_0E0D;
        mem[63] = 32'hDDCC_BBAA;

        tbl[0] = '{8'hEB, 24'h000000, 16, 64'h0102_0304_0506_0708, 1'b0};
        tbl[1] = '{8'hEB, 24'h000006,  6, 64'h0708_0900_0000_0000, 1'b0};
        tbl[2] = '{8'h9F, 24'h000000,  0, 64'h0,                   1'b1};
        tbl[3] = '{8'hEB, 24'h000000,  8, 64'h0102_0304_0000_0000, 1'b0};
        tbl[4] = '{8'hEB, 24'hFFFFFE,  8, 64'hCCDD_0102_0000_0000, 1'b0};
        tbl[5] = '{8'hEB, 24'h00000D,  6, 64'h0E0F_1000_0000_0000, 1'b0};
`ifdef QSPI_RESP_SINGLE_READ_EN
        tbl[6] = '{8'h03, 24'h000000,  8, 64'h0000_0002_0000_0000, 1'b0};
`else
        tbl[6] = '{8'h03, 24'h000000,  0, 64'h0,                   1'b1};
`endif

        clk_n(3);
        chk("reset_state", {io_i, oe, mem_req, mem_addr, busy, err}, 0);
        rst = 1'b0;
        clk_n(4);

        // directed table
        for (int v = 0; v < 7; v++) begin
            logic [63:0] e;
            logic [21:0] i0;
            e  = tbl[v].exp;
            i0 = tbl[v].addr[23:2];
            xfer(tbl[v].cmd, tbl[v].addr, tbl[v].n, tbl[v].cmd == 8'h03);
            if (tbl[v].ign) begin
                chk($sformatf("v%0d_ignore_req", v), req_idx.size(), 0);
                chk($sformatf("v%0d_ignore_oe", v), oe_early, 0);
            end else begin
                for (int k = 0; k < tbl[v].n; k++)
                    chk($sformatf("v%0d_unit%0d", v, k), rx[k], e[63-4*k -: 4]);
                chk($sformatf("v%0d_nreq", v), req_idx.size() >= 2, 1);
                chk($sformatf("v%0d_req0", v), req_idx[0], i0);
                chk($sformatf("v%0d_req1", v), req_idx[1], 22'(i0 + 22'd1));
                chk($sformatf("v%0d_oe_window", v), {oe_early, oe_missing}, 0);
            end
        end

        // abort after 3 nibbles, then a clean read of addr 4
        xfer(8'hEB, 24'h000000, 3, 0);
        xfer(8'hEB, 24'h000004, 4, 0);
        chk("abort_next_b0_hi", rx[0], 4'h0);
        chk("abort_next_b0_lo", rx[1], 4'h5);
        chk("abort_next_b1_hi", rx[2], 4'h0);
        chk("abort_next_b1_lo", rx[3], 4'h6);
        chk("err_clean_read", err, 0);

        // underrun: second word held back by 20 SCK periods
        slow_req = 1;
        slow_lat = 40 * H;
        xfer(8'hEB, 24'h000000, 24, 0);
        slow_req = -1;
        for (int k = 0; k < 8; k++)
            chk($sformatf("under_w0_unit%0d", k), rx[k], exp_unit(24'h0, k, 0));
        nz = 0;
        for (int k = 8; k < 18; k++) if (rx[k] != 4'h0) nz++;
        chk("under_zero_units", nz, 0);
        chk("under_err_sticky", err, 1);
        for (int t = 0; t < 600 && stub_left != 0; t++) clk_n(1);
        chk("under_stub_drained", stub_left, 0);
        clk_n(4);

        // reset pulsed mid-ADDR
        cs = 1'b0;
        clk_n(4);
        for (int i = 7; i >= 0; i--) sck_bit({3'b000, 8'hEB >> i} & 4'h1);
        sck_bit(4'h1); sck_bit(4'h2); sck_bit(4'h3);
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_addr_reset", {io_i, oe, mem_req, mem_addr, busy, err}, 0);
        cs = 1'b1;
        clk_n(3);
        rst = 1'b0;
        clk_n(6);

        // underrun flag clears on the next CS assertion
        xfer(8'hEB, 24'h000008, 4, 0);
        chk_read("post_reset", 24'h000008, 4, 0);
        chk("err_cleared", err, 0);

        // randomized reads against the byte model
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int t = 0; t < 8; t++) begin
            ra = 24'($urandom);
            rn = int'($urandom_range(2, 20));
            xfer(8'hEB, ra, rn, 0);
            chk_read($sformatf("rand%0d", t), ra, rn, 0);
        end

        chk("one_outstanding", stub_overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI flash responder: the target end of the quad-SPI link that `storage_controller` initiates on for external-storage reads. It decodes the command, address, mode and dummy phases clocked in by the initiator. It then streams words from a backing word memory back onto the quad data lines. It replaces the behavioural `qspi_stub` in system benches and serves as the FPGA flash emulator. Its pin names follow the initiator's naming: `_o` means driven by the initiator, and `qspi_io_i` is the data this block returns.

## Interface
- `ADDR_W`, 24: byte-address width received on the bus.
- `DUMMY_CYCLES`, 4: number of dummy SCK cycles after the mode byte for command 0xEB.
- `clk`  input  1  system clock. All logic is on `posedge clk`; `clk` must be at least 8x the SCK frequency.
- `rst`  input  1  synchronous, active-high reset.
- `qspi_ck_o`  input  1  SCK from the initiator; asynchronous to `clk`, idles low.
- `qspi_cs_o`  input  1  chip select from the initiator, active-low, asynchronous.
- `qspi_io_o`  input  4  data from the initiator.
- `qspi_io_i`  output  4  data driven back to the initiator.
- `qspi_oe`  output  1  high while this block owns the data lines (DATA state only).
- `mem_req`  output  1  one-cycle read request to the backing memory.
- `mem_addr`  output  ADDR_W-2  word index, equal to byte address >> 2.
- `mem_rdata`  input  32  read data; sampled when `mem_rvalid` is high.
- `mem_rvalid`  input  1  read-data valid. Arrives 1 or more cycles after `mem_req`, with at most one request outstanding.
- `busy`  output  1  high whenever the state is not IDLE.
- `err_underrun`  output  1  sticky underrun flag; cleared by `rst` or by the next CS assertion.

## Operation
- **Input synchronisation:** `ck`, `cs` and `io_o` each pass through a 2-flop synchroniser. A third flop on `ck` provides edge detection.
  - `sck_rise` = synchronised 0->1; `sck_fall` = synchronised 1->0.
  - `cs_act` = synchronised `cs` is low.
- **States:** IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
- **IDLE -> CMD** on `cs_act`. Clears the bit counter and `err_underrun`.
- **CMD:** shifts in `io_o[0]` on each `sck_rise`, MSB first, for 8 rises.
  - 0xEB -> ADDR.
  - Any other value -> IGNORE.
- **ADDR:** quad input, `io_o[3:0]`, high nibble first, 6 rises, yielding a 24-bit byte address. Then -> MODE.
- **MODE:** 2 rises; the value is discarded. On entry to MODE, issue `mem_req` for word `addr>>2`. Then -> DUMMY.
- **DUMMY:** counts `DUMMY_CYCLES` rises, then -> DATA.
- **DATA:**
  - The current word is loaded into a 32-bit shift register, starting at byte `addr[1:0]`.
  - Bytes go out little-endian (byte 0 = `[7:0]`), high nibble first.
  - A new nibble is presented on `qspi_io_i` at each `sck_fall`. The first nibble is presented at DATA entry.
  - When the shift register is loaded, `mem_req` is issued for the next word index, held in a one-word prefetch buffer.
  - The word index wraps from 2^(ADDR_W-2)-1 to 0.
- **Underrun:** a shift-register reload is needed but the prefetch buffer is empty.
  - Drive 4'h0, set `err_underrun`, and keep counting nibbles so alignment is preserved.
  - Load the word when it arrives; data is late, never shifted.
- **IGNORE:** `qspi_oe`=0 and no `mem_req` until CS deasserts.
- **CS deassert** (synchronised `cs` high) in any state -> IDLE on the next cycle.
  - `qspi_oe`=0 and the prefetch buffer is flushed.
  - An outstanding `mem_rvalid` is absorbed and discarded.
- **`rst`** overrides everything, including mid-transaction.

## Timing
- **Reset values:** state IDLE, `qspi_io_i`=4'h0, `qspi_oe`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `err_underrun`=0.
- **Pin to edge detect:** 3 `clk` cycles after a pin transition.
- **Output update:** `qspi_io_i` updates on the cycle after `sck_fall` is detected. The value is stable before the next SCK rise provided the SCK half-period is at least 4 `clk`.
- **Memory latency budget:** the first word must return within `DUMMY_CYCLES`+2 SCK periods of `mem_req`. Later words must return within 8 SCK periods.
- **CS deassertion:** `busy` falls within 4 `clk` cycles of the CS pin deasserting.
- **Simultaneous `mem_rvalid` and CS deassert:** the data is dropped.

## Configuration
- **`QSPI_RESP_SINGLE_READ_EN`** defined: command 0x03 is also accepted.
  - 24-bit address on `io_o[0]`, MSB first, 24 rises.
  - No mode byte and no dummy cycles.
  - Data on `qspi_io_i[1]` only, MSB-first per byte, one bit per `sck_fall`; `qspi_io_i[3:2,0]`=0.
- Not defined: 0x03 -> IGNORE.

## Test plan
- **Quad read:** mem[0]=32'h0403_0201, mem[1]=32'h0807_0605; send 0xEB, addr 0x000000, mode 0x00, 4 dummy -> nibbles 0,1,0,2,0,3,0,4,0,5,0,6,0,7,0,8. `mem_req` seen for indices 0 and 1.
- **Unaligned start:** addr 0x000006 -> first byte 0x07, then 0x08, then byte 0 of mem[2]. `qspi_oe`=1 only during DATA.
- **Unsupported command:** 0x9F -> no `mem_req`, `qspi_oe` stays 0, `busy` falls within 4 clk after CS high. A following 0xEB read of addr 0 is correct.
- **CS deasserted mid-word:** after 3 nibbles -> IDLE. The next read of addr 0x000004 returns 0x05,0x06 correctly, with no stale prefetch data.
- **Underrun:** memory stub delays `mem_rvalid` by 20 SCK periods on the second word -> zeros driven, `err_underrun`=1. The flag clears on the next CS assertion.
- **Reset and single-line read:** `rst` pulsed mid-ADDR -> all outputs at reset values the next cycle. With the macro defined, 0x03 addr 0 returns bit stream 0000_0001 on `io[1]`.
